// File: rtl/alu_pipe_ctrl_if.sv
// Operand/result handshake bundle for alu_pipe_ctrl.
// Operand side and result side each use their own valid/ready pair.
interface alu_pipe_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int ALUOP_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [ALUOP_W-1:0] m;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   y;
    logic               zf;
    logic               cf;
    logic               of;
    logic               busy;

    modport slave (
        input  in_valid, a, b, m, out_ready,
        output in_ready, out_valid, y, zf, cf, of, busy
    );

    modport master (
        output in_valid, a, b, m, out_ready,
        input  in_ready, out_valid, y, zf, cf, of, busy
    );
endinterface

// File: rtl/alu_pipe_ctrl.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus a
// WIDTH-cycle shift-add multiply; result held until consumed.
module alu_pipe_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ALUOP_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    alu_pipe_ctrl_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam logic [SH_W:0] LP_WV = (SH_W+1)'(WIDTH);
    localparam logic [SH_W-1:0] LP_LAST = SH_W'(WIDTH-1);

    localparam logic [ALUOP_W-1:0] OP_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] OP_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] OP_AND = 3'd2;
    localparam logic [ALUOP_W-1:0] OP_OR  = 3'd3;
    localparam logic [ALUOP_W-1:0] OP_XOR = 3'd4;
    localparam logic [ALUOP_W-1:0] OP_SHL = 3'd5;
    localparam logic [ALUOP_W-1:0] OP_SRA = 3'd6;
    localparam logic [ALUOP_W-1:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_y;
    logic               r_zf;
    logic               r_cf;
    logic               r_of;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [SH_W-1:0]    r_cnt;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_acc_nxt;

    logic [WIDTH-1:0]   w_res;
    logic               w_cf;
    logic               w_of;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_sra;
    logic [SH_W-1:0]    w_sh;
    logic               w_sh_big;
    logic               w_sh_zero;

    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_is_mul   = (bus.m == OP_MUL);
    assign w_mul_last = (r_cnt == LP_LAST);
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign w_sh      = bus.b[SH_W-1:0];
    assign w_sh_big  = ({1'b0, w_sh} >= LP_WV);
    assign w_sh_zero = (w_sh == '0);
    assign w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_dif     = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_shl     = {1'b0, bus.a} << w_sh;
    // Extra low bit catches the last bit shifted out of the right end.
    assign w_sra     = $signed({bus.a, 1'b0}) >>> w_sh;

    always_comb begin
        w_res = '0;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        unique case (bus.m)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_cf  = w_dif[WIDTH];
                w_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &
                        (w_dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_SHL: begin
                if (w_sh_big) begin
                    w_res = '0;
                end else begin
                    w_res = w_shl[WIDTH-1:0];
                    w_cf  = w_shl[WIDTH];
                end
            end
            OP_SRA: begin
                if (w_sh_big) begin
                    w_res = {WIDTH{bus.a[WIDTH-1]}};
                end else begin
                    w_res = w_sra[WIDTH:1];
                    w_cf  = w_sra[0] & ~w_sh_zero;
                end
            end
            OP_MUL: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_MUL : S_DONE;
                end else if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        if (rst) begin
            w_in_ready = (r_state == S_IDLE) |
                         ((r_state == S_DONE) & bus.out_ready);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_MUL);
    assign bus.y         = r_y;
    assign bus.zf        = r_zf;
    assign bus.cf        = r_cf;
    assign bus.of        = r_of;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y      <= '0;
            r_zf     <= 1'b0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_y  <= w_res;
            r_zf <= (w_res == '0);
            r_cf <= w_cf;
            r_of <= w_of;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_y  <= w_acc_nxt[WIDTH-1:0];
                r_zf <= (w_acc_nxt[WIDTH-1:0] == '0);
                r_cf <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_of <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Randomized + directed bench for alu_pipe_ctrl (WIDTH 8 and 3)
// against an integer-arithmetic reference model.
module tb_alu_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe_ctrl_if #(.WIDTH(8), .ALUOP_W(3)) bus ();
    alu_pipe_ctrl_if #(.WIDTH(3), .ALUOP_W(3)) bus3 ();

    alu_pipe_ctrl #(.WIDTH(8), .ALUOP_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    alu_pipe_ctrl #(.WIDTH(3), .ALUOP_W(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_alu(input int w, input int ua, input int ub,
                                    input int op, output int ry,
                                    output bit rz, output bit rc,
                                    output bit ro);
        int md, mx, mn, sa, sb, r, sr, s;
        md = 1 << w;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        sa = (ua > mx) ? ua - md : ua;
        sb = (ub > mx) ? ub - md : ub;
        s  = ub % (1 << $clog2(w));
        ry = 0; rc = 0; ro = 0;
        case (op)
            0: begin
                r = ua + ub; ry = r % md; rc = (r >= md);
                sr = sa + sb; ro = (sr > mx) || (sr < mn);
            end
            1: begin
                r = ua - ub; ry = (r + md) % md; rc = (ua < ub);
                sr = sa - sb; ro = (sr > mx) || (sr < mn);
            end
            2: ry = ua & ub;
            3: ry = ua | ub;
            4: ry = ua ^ ub;
            5: begin
                if (s == 0) ry = ua;
                else if (s < w) begin
                    ry = (ua << s) % md; rc = ((ua >> (w - s)) & 1) != 0;
                end
            end
            6: begin
                if (s == 0) ry = ua;
                else if (s >= w) ry = (sa < 0) ? md - 1 : 0;
                else begin
                    ry = ((sa >>> s) + md) % md;
                    rc = ((ua >> (s - 1)) & 1) != 0;
                end
            end
            default: begin
                r = ua * ub; ry = r % md; rc = (r >= md); ro = rc;
            end
        endcase
        rz = (ry == 0);
    endfunction

    task automatic run_op(input int a, input int b, input int op,
                          input string tag);
        int ey, nb;
        bit ez, ec, eo, rb;
        ref_alu(8, a, b, op, ey, ez, ec, eo);
        bus.in_valid = 1'b1;
        bus.a = a[7:0];
        bus.b = b[7:0];
        bus.m = op[2:0];
        bus.out_ready = 1'b0;
        nb = 0;
        while (!bus.in_ready && nb < 40) begin
            step();
            nb++;
        end
        chk({tag, " in_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.m = 3'($urandom);
        if (op == 7) begin
            nb = 0;
            rb = 0;
            for (int i = 0; i < 40 && !bus.out_valid; i++) begin
                if (bus.busy) nb++;
                if (bus.in_ready) rb = 1;
                step();
            end
            chk({tag, " busy_cycles"}, nb, 8);
            chk({tag, " ready_in_mul"}, rb, 0);
        end
        chk({tag, " out_valid"}, bus.out_valid, 1);
        chk({tag, " y"}, bus.y, ey);
        chk({tag, " zf"}, bus.zf, ez);
        chk({tag, " cf"}, bus.cf, ec);
        chk({tag, " of"}, bus.of, eo);
        chk({tag, " busy"}, bus.busy, 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, " retired"}, bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ey, ta, tb, top;
        bit ez, ec, eo;
        bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.m = 0;
        bus.out_ready = 0;
        bus3.in_valid = 0; bus3.a = 0; bus3.b = 0; bus3.m = 0;
        bus3.out_ready = 0;
        #3;
        chk("rst y", bus.y, 0);
        chk("rst flags", {bus.zf, bus.cf, bus.of}, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst busy", bus.busy, 0);
        bus.in_valid = 1'b1;
        #1;
        chk("rst in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("idle in_ready", bus.in_ready, 1);

        run_op(8'h7F, 8'h01, 0, "add_ovf");
        run_op(8'h00, 8'h01, 1, "sub_borrow");
        run_op(8'h80, 8'h01, 1, "sub_ovf");
        run_op(5, 5, 1, "sub_zero");
        run_op(8'h10, 8'h11, 7, "mul_ovf");
        run_op(3, 4, 7, "mul_small");
        run_op(8'h81, 1, 6, "sra1");
        run_op(8'h81, 1, 5, "shl1");
        run_op(8'hA5, 0, 5, "shl0");
        run_op(8'hA5, 8, 6, "sra0");
        run_op(8'hFF, 8'hFF, 7, "mul_max");

        bus.in_valid = 1; bus.a = 8'h12; bus.b = 8'h34; bus.m = 0;
        step();
        bus.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold out_valid", bus.out_valid, 1);
            chk("hold y", bus.y, 8'h46);
            chk("hold flags", {bus.zf, bus.cf, bus.of}, 0);
            chk("hold in_ready", bus.in_ready, 0);
            step();
        end
        bus.in_valid = 1; bus.a = 8'hF0; bus.b = 8'h0F; bus.m = 4;
        bus.out_ready = 1;
        #1;
        chk("swap in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 0;
        bus.out_ready = 0;
        chk("swap out_valid", bus.out_valid, 1);
        chk("swap y", bus.y, 8'hFF);
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;

        bus.out_ready = 1;
        for (int i = 0; i < 24; i++) begin
            ta = int'($urandom_range(0, 255));
            tb = int'($urandom_range(0, 255));
            top = int'($urandom_range(0, 6));
            ref_alu(8, ta, tb, top, ey, ez, ec, eo);
            bus.in_valid = 1; bus.a = ta[7:0]; bus.b = tb[7:0];
            bus.m = top[2:0];
            step();
            chk("b2b out_valid", bus.out_valid, 1);
            chk("b2b y", bus.y, ey);
            chk("b2b flags", {bus.zf, bus.cf, bus.of}, {ez, ec, eo});
        end
        bus.in_valid = 0;
        step();
        bus.out_ready = 0;
        chk("b2b drained", bus.out_valid, 0);

        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 7)), "rand");
        end

        bus.in_valid = 1; bus.a = 8'h10; bus.b = 8'h11; bus.m = 7;
        step();
        bus.in_valid = 0;
        step();
        step();
        step();
        chk("mid_mul busy", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async busy", bus.busy, 0);
        chk("async out_valid", bus.out_valid, 0);
        chk("async in_ready", bus.in_ready, 0);
        chk("async y", bus.y, 0);
        chk("async flags", {bus.zf, bus.cf, bus.of}, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("no stale", bus.out_valid, 0);
        end
        run_op(3, 5, 7, "post_rst_mul");

        bus3.out_ready = 1;
        bus3.in_valid = 1;
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 8; a++) begin
                for (int b = 0; b < 8; b++) begin
                    ref_alu(3, a, b, op, ey, ez, ec, eo);
                    bus3.a = a[2:0]; bus3.b = b[2:0]; bus3.m = op[2:0];
                    step();
                    chk("w3 out_valid", bus3.out_valid, 1);
                    chk("w3 y", bus3.y, ey);
                    chk("w3 flags", {bus3.zf, bus3.cf, bus3.of},
                        {ez, ec, eo});
                end
            end
        end
        bus3.in_valid = 0;
        step();
        chk("w3 drained", bus3.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
